ahb_dma_copy: RTL

- Single-channel AHB-Lite manager (initiator) that copies Len bus words from SrcAdr to DstAdr.
- Sits on the manager side of the uncore AHB fabric and drives the same HADDR/HTRANS/HWRITE signals the subordinates decode.
- Intended use: boot-time image copy (e.g. boot ROM to RAM) and peripheral buffer moves, without core involvement.
- Transfers are single NONSEQ beats: each word is read, then written.

---
 rtl/ahb_dma_pkg.sv | 19 +
 rtl/dma_ptrctr.sv | 56 +++++
 rtl/ahb_dma_copy.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ahb_dma_pkg.sv
// Shared types and AHB-Lite encodings for the single-channel copy engine.
// No ports; imported by dma_ptrctr and ahb_dma_copy.
package ahb_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRda,  // read address phase
    StRdd,  // read data phase
    StWra,  // write address phase
    StWrd,  // write data phase
    StFin
  } dma_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

endpackage

// File: rtl/dma_ptrctr.sv
// Loadable source/destination pointers and remaining-word counter.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   load               capture src_in/dst_in/len_in
//   advance            step both pointers by STRIDE bytes and decrement the count
//   src_ptr, dst_ptr   current byte addresses (wrap modulo 2^PA_BITS)
//   count              words remaining
//   last               count == 1, i.e. the current word is the final one
module dma_ptrctr
  import ahb_dma_pkg::*;
#(
  parameter int unsigned PA_BITS  = 32,
  parameter int unsigned LEN_BITS = 16,
  parameter int unsigned STRIDE   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                advance,
  input  logic [PA_BITS-1:0]  src_in,
  input  logic [PA_BITS-1:0]  dst_in,
  input  logic [LEN_BITS-1:0] len_in,
  output logic [PA_BITS-1:0]  src_ptr,
  output logic [PA_BITS-1:0]  dst_ptr,
  output logic [LEN_BITS-1:0] count,
  output logic                last
);

  localparam logic [PA_BITS-1:0]  Step = PA_BITS'(STRIDE);
  localparam logic [LEN_BITS-1:0] One  = LEN_BITS'(1);

  logic [PA_BITS-1:0]  src_q, dst_q;
  logic [LEN_BITS-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      src_q <= src_in;
      dst_q <= dst_in;
      cnt_q <= len_in;
    end else if (advance) begin
      src_q <= src_q + Step;
      dst_q <= dst_q + Step;
      cnt_q <= cnt_q - One;
    end
  end

  assign src_ptr = src_q;
  assign dst_ptr = dst_q;
  assign count   = cnt_q;
  assign last    = (cnt_q == One);

endmodule

// File: rtl/ahb_dma_copy.sv
// Single-channel AHB-Lite manager copying Len bus words from SrcAdr to DstAdr,
// one NONSEQ read followed by one NONSEQ write per word.
// Ports:
//   clk, reset                  HCLK and synchronous active-high reset
//   Start, SrcAdr, DstAdr, Len  request; accepted only while idle
//   Busy, Done, Err             status (Err is sticky until the next accepted Start)
//   HADDR..HMASTLOCK            AHB-Lite manager address/control/write-data outputs
//   HRDATA, HREADY, HRESP       AHB-Lite subordinate responses
// Optional: define AHB_DMA_ABORT_EN to add the Abort input, which ends the copy after
// the bus data phase currently in flight.
module ahb_dma_copy
  import ahb_dma_pkg::*;
#(
  parameter int unsigned PA_BITS  = 32,
  parameter int unsigned AHBW     = 64,
  parameter int unsigned LEN_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Start,
  input  logic [PA_BITS-1:0]  SrcAdr,
  input  logic [PA_BITS-1:0]  DstAdr,
  input  logic [LEN_BITS-1:0] Len,
`ifdef AHB_DMA_ABORT_EN
  input  logic                Abort,
`endif
  output logic                Busy,
  output logic                Done,
  output logic                Err,
  output logic [PA_BITS-1:0]  HADDR,
  output logic [AHBW-1:0]     HWDATA,
  output logic [AHBW/8-1:0]   HWSTRB,
  output logic                HWRITE,
  output logic [2:0]          HSIZE,
  output logic [2:0]          HBURST,
  output logic [3:0]          HPROT,
  output logic [1:0]          HTRANS,
  output logic                HMASTLOCK,
  input  logic [AHBW-1:0]     HRDATA,
  input  logic                HREADY,
  input  logic                HRESP
);

  localparam logic [2:0] HSizeW = (AHBW == 64) ? 3'd3 : 3'd2;

  dma_state_t          state_q, state_d;
  logic                done_q, err_q;
  logic [AHBW-1:0]     buf_q;
  logic [PA_BITS-1:0]  haddr_q;
  logic                load, advance, capture, err_set, abort_now;
  logic [PA_BITS-1:0]  src_ptr, dst_ptr;
  logic [LEN_BITS-1:0] count;
  logic                last;

  dma_ptrctr #(
    .PA_BITS  (PA_BITS),
    .LEN_BITS (LEN_BITS),
    .STRIDE   (AHBW / 8)
  ) u_ptrctr (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .src_in  (SrcAdr),
    .dst_in  (DstAdr),
    .len_in  (Len),
    .src_ptr (src_ptr),
    .dst_ptr (dst_ptr),
    .count   (count),
    .last    (last)
  );

`ifdef AHB_DMA_ABORT_EN
  logic abort_q;
  always_ff @(posedge clk) begin
    if (reset || load) begin
      abort_q <= 1'b0;
    end else if (Abort && Busy) begin
      abort_q <= 1'b1;
    end
  end
  // Only consulted at data-phase completion, so address phases are never cut.
  assign abort_now = abort_q | (Abort & Busy);
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    capture = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          load    = 1'b1;
          state_d = (Len == '0) ? StFin : StRda;
        end
      end
      StRda: if (HREADY) state_d = StRdd;
      StRdd: begin
        // Flag on either cycle of the two-cycle error response, leave on the HREADY one.
        if (HRESP) err_set = 1'b1;
        if (HREADY) begin
          if (HRESP || abort_now) begin
            state_d = StFin;
          end else begin
            capture = 1'b1;
            state_d = StWra;
          end
        end
      end
      StWra: if (HREADY) state_d = StWrd;
      StWrd: begin
        if (HRESP) begin
          err_set = 1'b1;
          state_d = StFin;
        end else if (HREADY) begin
          advance = 1'b1;
          state_d = (last || abort_now) ? StFin : StRda;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      buf_q   <= '0;
      haddr_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StFin);
      if (load) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
      if (capture) buf_q <= HRDATA;
      haddr_q <= HADDR;
    end
  end

  // HADDR follows the live pointer in address phases and otherwise holds its last value.
  always_comb begin
    unique case (state_q)
      StRda:   HADDR = src_ptr;
      StWra:   HADDR = dst_ptr;
      default: HADDR = haddr_q;
    endcase
  end

  assign HTRANS    = (state_q == StRda || state_q == StWra) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE    = (state_q == StWra);
  assign HWDATA    = buf_q;
  assign HWSTRB    = '1;
  assign HSIZE     = HSizeW;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;
  assign Busy      = (state_q != StIdle);
  assign Done      = done_q;
  assign Err       = err_q;

  logic unused_count;
  assign unused_count = ^count;

endmodule
